// File: rtl/drawing_canvas_brush_pkg.sv
// Shared definitions for the brush canvas frame store.
// Provides the pixel colour width, the "empty" colour that clears write,
// and a small palette used by callers and the bench.
package drawing_canvas_brush_pkg;

  localparam int COLOR_WIDTH = 8;

  localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 8'h00;
  localparam logic [COLOR_WIDTH-1:0] COLOR_BLACK = 8'h01;
  localparam logic [COLOR_WIDTH-1:0] COLOR_RED   = 8'hE0;
  localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN = 8'h1C;
  localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE  = 8'h03;
  localparam logic [COLOR_WIDTH-1:0] COLOR_WHITE = 8'hFF;

endpackage

// File: rtl/canvas_ram.sv
// Canvas pixel store: one synchronous write port and one registered read
// port. A read and a write to the same address in the same cycle return
// the old contents; the new value is visible one cycle later.
//
// Ports:
//   clk      clock
//   rd_clr   forces the read register to RESET_COLOR (used during reset)
//   we       write enable
//   wr_addr  linear write address (y*WIDTH + x)
//   wr_data  write colour
//   rd_addr  linear read address (y*WIDTH + x)
//   rd_data  registered read colour, 1-cycle latency
module canvas_ram #(
  parameter int                     WIDTH       = 640,
  parameter int                     HEIGHT      = 480,
  parameter int                     COLOR_WIDTH = 8,
  parameter logic [COLOR_WIDTH-1:0] RESET_COLOR = {COLOR_WIDTH{1'b0}},
  localparam int                    AW          = $clog2(WIDTH * HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rd_clr,
  input  logic                   we,
  input  logic [AW-1:0]          wr_addr,
  input  logic [COLOR_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]          rd_addr,
  output logic [COLOR_WIDTH-1:0] rd_data
);

  logic [COLOR_WIDTH-1:0] mem [WIDTH*HEIGHT];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; non-blocking update gives read-before-write.
  always_ff @(posedge clk) begin
    if (rd_clr) begin
      rd_data <= RESET_COLOR;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/drawing_canvas_brush.sv
// Canvas frame store with a square (optionally round) brush stamp, a
// full-canvas clear sweep, ready/valid stroke intake and a never-stalling
// display read port.
//
// Optional feature macro: DRAWING_CANVAS_ROUND_BRUSH_EN
//   defined   -> stamp positions with dx*dx+dy*dy > r*r are suppressed (disc)
//   undefined -> square brush, no multiplier logic
//
// Ports:
//   clk, reset_n   clock, synchronous active-low reset (starts a clear)
//   stroke_valid   stroke request present
//   stroke_ready   stroke accepted when valid && ready at posedge
//   tool_x/tool_y  brush centre
//   tool_color     stroke colour
//   brush_size     radius r (0 = single pixel), saturates at MAX_BRUSH
//   clear_req      one-cycle pulse requesting a full clear
//   busy           stamp or clear in progress
//   pixel_x/_y     display read address
//   pixel_color    registered display read data (1-cycle latency)
module drawing_canvas_brush
  import drawing_canvas_brush_pkg::*;
#(
  parameter int  WIDTH     = 640,
  parameter int  HEIGHT    = 480,
  parameter int  MAX_BRUSH = 3,
  localparam int XW        = $clog2(WIDTH),
  localparam int YW        = $clog2(HEIGHT),
  localparam int BW        = $clog2(MAX_BRUSH + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   stroke_valid,
  output logic                   stroke_ready,
  input  logic [XW-1:0]          tool_x,
  input  logic [YW-1:0]          tool_y,
  input  logic [COLOR_WIDTH-1:0] tool_color,
  input  logic [BW-1:0]          brush_size,
  input  logic                   clear_req,
  output logic                   busy,
  input  logic [XW-1:0]          pixel_x,
  input  logic [YW-1:0]          pixel_y,
  output logic [COLOR_WIDTH-1:0] pixel_color
);

  localparam int OW   = BW + 1;           // signed brush offset width
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW   = $clog2(NPIX);

  localparam logic [AW-1:0]        LAST_ADDR = AW'(NPIX - 1);
  localparam logic [XW:0]          X_LIM     = (XW + 1)'(WIDTH);
  localparam logic [YW:0]          Y_LIM     = (YW + 1)'(HEIGHT);
  localparam logic [BW-1:0]        R_MAX     = BW'(MAX_BRUSH);
  localparam logic signed [OW-1:0] ONE_S     = {{(OW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]        ONE_A     = {{(AW-1){1'b0}}, 1'b1};

  typedef logic [1:0] canvas_state_t;
  localparam canvas_state_t ST_IDLE  = 2'd0;
  localparam canvas_state_t ST_STAMP = 2'd1;
  localparam canvas_state_t ST_CLEAR = 2'd2;

  canvas_state_t          state_r;
  logic                   clear_pending_r;
  logic [XW-1:0]          x_r;
  logic [YW-1:0]          y_r;
  logic [COLOR_WIDTH-1:0] color_r;
  logic [BW-1:0]          r_r;
  logic signed [OW-1:0]   dx_r;
  logic signed [OW-1:0]   dy_r;
  logic [AW-1:0]          clr_cnt_r;

  logic [BW-1:0]          r_sat_s;
  logic signed [OW-1:0]   r_pos_s;
  logic signed [XW:0]     tx_s;
  logic signed [YW:0]     ty_s;
  logic                   in_bounds_s;
  logic                   in_shape_s;
  logic [AW-1:0]          stamp_addr_s;
  logic                   we_s;
  logic [AW-1:0]          wr_addr_s;
  logic [COLOR_WIDTH-1:0] wr_data_s;
  logic [AW-1:0]          rd_addr_s;

  assign r_sat_s = (brush_size > R_MAX) ? R_MAX : brush_size;
  assign r_pos_s = $signed({1'b0, r_r});

  // Target position, one bit wider than the coordinates; positions that
  // fall off either edge (including overflow past the top) come out
  // negative or >= the limit and are clipped rather than wrapped.
  assign tx_s = $signed({1'b0, x_r}) + (XW + 1)'(dx_r);
  assign ty_s = $signed({1'b0, y_r}) + (YW + 1)'(dy_r);

  assign in_bounds_s = !tx_s[XW] && !ty_s[YW] &&
                       (unsigned'(tx_s) < X_LIM) && (unsigned'(ty_s) < Y_LIM);

`ifdef DRAWING_CANVAS_ROUND_BRUSH_EN
  assign in_shape_s = (int'(dx_r) * int'(dx_r) + int'(dy_r) * int'(dy_r)) <=
                      (int'(r_pos_s) * int'(r_pos_s));
`else
  assign in_shape_s = 1'b1;
`endif

  assign stamp_addr_s = AW'(ty_s[YW-1:0]) * AW'(WIDTH) + AW'(tx_s[XW-1:0]);
  assign rd_addr_s    = AW'(pixel_y) * AW'(WIDTH) + AW'(pixel_x);

  assign stroke_ready = (state_r == ST_IDLE) && !clear_pending_r && !clear_req;
  assign busy         = (state_r != ST_IDLE);

  // Write-port steering: in-canvas stamp pixels or the clear sweep.
  always_comb begin
    we_s      = 1'b0;
    wr_addr_s = {AW{1'b0}};
    wr_data_s = COLOR_NONE;
    if (!reset_n) begin
      we_s = 1'b0;
    end else begin
      case (state_r)
        ST_STAMP: begin
          we_s      = in_bounds_s && in_shape_s;
          wr_addr_s = stamp_addr_s;
          wr_data_s = color_r;
        end
        ST_CLEAR: begin
          we_s      = 1'b1;
          wr_addr_s = clr_cnt_r;
          wr_data_s = COLOR_NONE;
        end
        default: begin
          we_s = 1'b0;
        end
      endcase
    end
  end

  // Control FSM: stroke intake, brush raster walk and clear sweep.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r         <= ST_CLEAR;
      clr_cnt_r       <= {AW{1'b0}};
      clear_pending_r <= 1'b0;
      x_r             <= {XW{1'b0}};
      y_r             <= {YW{1'b0}};
      color_r         <= COLOR_NONE;
      r_r             <= {BW{1'b0}};
      dx_r            <= {OW{1'b0}};
      dy_r            <= {OW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (clear_req || clear_pending_r) begin
            state_r         <= ST_CLEAR;
            clr_cnt_r       <= {AW{1'b0}};
            clear_pending_r <= 1'b0;
          end else if (stroke_valid) begin
            x_r     <= tool_x;
            y_r     <= tool_y;
            color_r <= tool_color;
            r_r     <= r_sat_s;
            dx_r    <= -$signed({1'b0, r_sat_s});
            dy_r    <= -$signed({1'b0, r_sat_s});
            state_r <= ST_STAMP;
          end
        end
        ST_STAMP: begin
          if (clear_req) begin
            clear_pending_r <= 1'b1;
          end
          if (dx_r == r_pos_s) begin
            dx_r <= -r_pos_s;
            if (dy_r == r_pos_s) begin
              state_r <= ST_IDLE;
            end else begin
              dy_r <= dy_r + ONE_S;
            end
          end else begin
            dx_r <= dx_r + ONE_S;
          end
        end
        ST_CLEAR: begin
          if (clear_req) begin
            clear_pending_r <= 1'b1;
          end
          if (clr_cnt_r == LAST_ADDR) begin
            state_r <= ST_IDLE;
          end else begin
            clr_cnt_r <= clr_cnt_r + ONE_A;
          end
        end
        default: begin
          state_r   <= ST_CLEAR;
          clr_cnt_r <= {AW{1'b0}};
        end
      endcase
    end
  end

  canvas_ram #(
    .WIDTH       (WIDTH),
    .HEIGHT      (HEIGHT),
    .COLOR_WIDTH (COLOR_WIDTH),
    .RESET_COLOR (COLOR_NONE)
  ) u_ram (
    .clk     (clk),
    .rd_clr  (!reset_n),
    .we      (we_s),
    .wr_addr (wr_addr_s),
    .wr_data (wr_data_s),
    .rd_addr (rd_addr_s),
    .rd_data (pixel_color)
  );

endmodule

// File: tb/tb_drawing_canvas_brush.sv
module tb_drawing_canvas_brush;
  import drawing_canvas_brush_pkg::*;

  localparam int W     = 8;
  localparam int H     = 8;
  localparam int MB    = 2;
  localparam int LIMIT = 400;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   stroke_valid;
  logic                   stroke_ready;
  logic [2:0]             tool_x;
  logic [2:0]             tool_y;
  logic [COLOR_WIDTH-1:0] tool_color;
  logic [1:0]             brush_size;
  logic                   clear_req;
  logic                   busy;
  logic [2:0]             pixel_x;
  logic [2:0]             pixel_y;
  logic [COLOR_WIDTH-1:0] pixel_color;

  int model [W][H];
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  drawing_canvas_brush #(.WIDTH(W), .HEIGHT(H), .MAX_BRUSH(MB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stroke_valid (stroke_valid),
    .stroke_ready (stroke_ready),
    .tool_x       (tool_x),
    .tool_y       (tool_y),
    .tool_color   (tool_color),
    .brush_size   (brush_size),
    .clear_req    (clear_req),
    .busy         (busy),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .pixel_color  (pixel_color)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: every canvas cell the brush covers, computed directly.
  task automatic model_stroke(input int x, input int y, input int c, input int bs);
    int r;
    r = (bs > MB) ? MB : bs;
    for (int dy = -r; dy <= r; dy++)
      for (int dx = -r; dx <= r; dx++) begin
        bit hit;
        hit = (x + dx >= 0) && (x + dx < W) && (y + dy >= 0) && (y + dy < H);
`ifdef DRAWING_CANVAS_ROUND_BRUSH_EN
        if (dx * dx + dy * dy > r * r) hit = 1'b0;
`endif
        if (hit) model[x + dx][y + dy] = c;
      end
  endtask

  task automatic model_clear();
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) model[x][y] = int'(COLOR_NONE);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < LIMIT) begin
      n++;
      tick();
    end
  endtask

  task automatic scan(input string tag);
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) begin
        pixel_x = 3'(x);
        pixel_y = 3'(y);
        tick();
        check($sformatf("%s(%0d,%0d)", tag, x, y), int'(pixel_color), model[x][y]);
      end
  endtask

  task automatic do_stroke(input string tag, input int x, input int y, input int c, input int bs);
    int n, r;
    r = (bs > MB) ? MB : bs;
    tool_x       = 3'(x);
    tool_y       = 3'(y);
    tool_color   = COLOR_WIDTH'(c);
    brush_size   = 2'(bs);
    stroke_valid = 1'b1;
    check({tag, "_ready"}, int'(stroke_ready), 1);
    tick();
    stroke_valid = 1'b0;
    wait_idle(n);
    check({tag, "_cycles"}, n, (2 * r + 1) * (2 * r + 1));
    model_stroke(x, y, c, bs);
  endtask

  initial begin
    int n, ready_seen;
    reset_n      = 1'b0;
    stroke_valid = 1'b0;
    tool_x       = 3'd0;
    tool_y       = 3'd0;
    tool_color   = COLOR_NONE;
    brush_size   = 2'd0;
    clear_req    = 1'b0;
    pixel_x      = 3'd0;
    pixel_y      = 3'd0;
    model_clear();

    // Reset held two cycles, then the power-up clear sweep.
    tick();
    tick();
    check("rst_busy", int'(busy), 1);
    check("rst_ready", int'(stroke_ready), 0);
    check("rst_pixel", int'(pixel_color), int'(COLOR_NONE));
    reset_n    = 1'b1;
    n          = 0;
    ready_seen = 0;
    while (busy && n < LIMIT) begin
      if (stroke_ready) ready_seen++;
      n++;
      tick();
    end
    check("rst_clear_cycles", n, W * H);
    check("rst_clear_ready", ready_seen, 0);
    scan("after_reset");

    // Directed strokes: centre, pre-painted corners, edge clip, saturation.
    do_stroke("blue_r1", 4, 4, int'(COLOR_BLUE), 1);
    do_stroke("red_77", 7, 7, int'(COLOR_RED), 0);
    do_stroke("green_00", 0, 0, int'(COLOR_GREEN), 0);
    do_stroke("white_07", 0, 7, int'(COLOR_WHITE), 2);
    scan("clip");
    do_stroke("sat", 4, 4, int'(COLOR_BLACK), 3);
    scan("sat");

    // Clear requested mid-stamp, then again together with a stroke in IDLE.
    tool_x = 3'd2; tool_y = 3'd2; tool_color = COLOR_RED; brush_size = 2'd2;
    stroke_valid = 1'b1;
    check("mid_ready", int'(stroke_ready), 1);
    tick();
    stroke_valid = 1'b0;
    n = 0;
    while (busy && n < LIMIT) begin
      clear_req = (n == 5);
      n++;
      tick();
    end
    clear_req = 1'b0;
    check("mid_stamp_cycles", n, 25);
    model_stroke(2, 2, int'(COLOR_RED), 2);
    check("pending_ready", int'(stroke_ready), 0);
    tool_x = 3'd5; tool_y = 3'd5; tool_color = COLOR_WHITE; brush_size = 2'd1;
    stroke_valid = 1'b1;
    clear_req    = 1'b1;
    check("clr_vs_stroke_ready", int'(stroke_ready), 0);
    tick();
    stroke_valid = 1'b0;
    clear_req    = 1'b0;
    wait_idle(n);
    check("pending_clear_cycles", n, W * H);
    model_clear();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy) n++;
      tick();
    end
    check("no_second_clear", n, 0);
    scan("after_clear");

    // Same-address read and write: old value first, new value next cycle.
    pixel_x = 3'd4; pixel_y = 3'd4;
    tool_x = 3'd4; tool_y = 3'd4; tool_color = COLOR_GREEN; brush_size = 2'd0;
    stroke_valid = 1'b1;
    tick();
    stroke_valid = 1'b0;
    tick();
    check("rbw_old", int'(pixel_color), int'(COLOR_NONE));
    check("rbw_busy_done", int'(busy), 0);
    tick();
    check("rbw_new", int'(pixel_color), int'(COLOR_GREEN));
    model_stroke(4, 4, int'(COLOR_GREEN), 0);

    // Randomized strokes with an occasional clear.
    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_idle(n);
        check("rand_clear_cycles", n, W * H);
        model_clear();
      end
      do_stroke($sformatf("rand%0d", i), int'($urandom_range(7, 0)),
                int'($urandom_range(7, 0)), int'($urandom_range(255, 1)),
                int'($urandom_range(3, 0)));
      if (i % 4 == 3) scan($sformatf("rand_scan%0d", i));
    end
    scan("final");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
